// File: rtl/ysyx_23060203_wbu_arb.sv
// ============================================================================
// Module  : ysyx_23060203_wbu_arb
// Brief   : Writeback arbiter (ALU/LSU round-robin) with GPR busy scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_23060203_wbu_arb #(
    parameter int NR_REG = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    output logic        issue_ready,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        lsu_valid,
    input  logic [4:0]  lsu_rd,
    input  logic [31:0] lsu_data,
    output logic        lsu_ready,
    output logic        gpr_wen,
    output logic [4:0]  gpr_waddr,
    output logic [31:0] gpr_wdata,
    input  logic [4:0]  chk_rs1,
    input  logic [4:0]  chk_rs2,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic        wb_err
);

    localparam logic [5:0] NR = 6'(NR_REG);

    logic [NR_REG-1:1] busy;
    logic [31:0]       busy_map;
    logic              pref;
    logic              wb_fire;
    logic [4:0]        wb_rd;
    logic [31:0]       wb_data;
    logic              wb_rd_ok;
    logic              wb_owed;
    logic              wb_stray;
    logic              issue_fire;

    // x0 and out-of-range indices map to constant zero entries.
    always_comb begin
        busy_map                = '0;
        busy_map[NR_REG-1:1]    = busy;
    end

    assign issue_ready = ~busy_map[issue_rd];
    assign rs1_busy    = busy_map[chk_rs1];
    assign rs2_busy    = busy_map[chk_rs2];

    assign alu_ready = alu_valid && (!lsu_valid || !pref);
    assign lsu_ready = lsu_valid && (!alu_valid || pref);

    assign wb_fire  = alu_ready || lsu_ready;
    assign wb_rd    = lsu_ready ? lsu_rd   : alu_rd;
    assign wb_data  = lsu_ready ? lsu_data : alu_data;
    assign wb_rd_ok = (wb_rd != 5'd0) && ({1'b0, wb_rd} < NR);

    // A writeback already committing this cycle has consumed the pending slot,
    // even though its busy bit only clears at the end of the cycle.
    assign wb_owed  = busy_map[wb_rd] && !(gpr_wen && (gpr_waddr == wb_rd));
    assign wb_stray = wb_fire && wb_rd_ok && !wb_owed;

    assign issue_fire = issue_valid && issue_ready && (issue_rd != 5'd0)
                        && ({1'b0, issue_rd} < NR);

    always_ff @(posedge clock) begin
        if (!reset) begin
            busy      <= '0;
            pref      <= 1'b0;
            gpr_wen   <= 1'b0;
            gpr_waddr <= 5'd0;
            gpr_wdata <= 32'd0;
            wb_err    <= 1'b0;
        end else begin
            if (wb_fire) begin
                pref      <= alu_ready;
                gpr_waddr <= wb_rd;
                gpr_wdata <= wb_data;
            end
            gpr_wen <= wb_fire && wb_rd_ok;
            if (wb_stray) begin
                wb_err <= 1'b1;
            end
            for (int i = 1; i < NR_REG; i++) begin
                if (gpr_wen && (gpr_waddr == 5'(i))) begin
                    busy[i] <= 1'b0;
                end
                if (issue_fire && (issue_rd == 5'(i))) begin
                    busy[i] <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060203_wbu_arb.sv
// ============================================================================
// Module  : tb_ysyx_23060203_wbu_arb
// Brief   : Directed + randomised bench with a behavioural scoreboard model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_23060203_wbu_arb;

    localparam int NR = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        lsu_valid;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        lsu_ready;
    logic        gpr_wen;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata;
    logic [4:0]  chk_rs1;
    logic [4:0]  chk_rs2;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        wb_err;

    int total = 0;
    int bad   = 0;
    bit checking = 1'b0;

    ysyx_23060203_wbu_arb #(.NR_REG(NR)) dut (
        .clock(clock), .reset(reset),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .wb_err(wb_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Model: 'pending' = visible busy bit (clears on commit),
    // 'owed' = a writeback is still expected (clears on acceptance).
    bit          m_pending [32];
    bit          m_owed    [32];
    bit          m_last_alu;          // 1: ALU got the most recent grant
    bit          m_wen;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    bit          m_err;

    function automatic bit real_reg(input logic [4:0] r);
        return (r != 0) && (int'(r) < NR);
    endfunction

    function automatic bit m_busy(input logic [4:0] r);
        return real_reg(r) && m_pending[r];
    endfunction

    function automatic bit m_grant_alu();
        if (!alu_valid) return 1'b0;
        if (!lsu_valid) return 1'b1;
        return !m_last_alu;
    endfunction

    function automatic bit m_grant_lsu();
        if (!lsu_valid) return 1'b0;
        if (!alu_valid) return 1'b1;
        return m_last_alu;
    endfunction

    always @(posedge clock) begin
        bit          ga, gl, iss;
        logic [4:0]  r;
        logic [31:0] d;
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                m_pending[i] = 1'b0;
                m_owed[i]    = 1'b0;
            end
            m_last_alu = 1'b0;
            m_wen      = 1'b0;
            m_waddr    = 5'd0;
            m_wdata    = 32'd0;
            m_err      = 1'b0;
        end else begin
            ga  = m_grant_alu();
            gl  = m_grant_lsu();
            iss = issue_valid && !m_busy(issue_rd) && real_reg(issue_rd);
            r   = gl ? lsu_rd : alu_rd;
            d   = gl ? lsu_data : alu_data;
            if (m_wen) m_pending[m_waddr] = 1'b0;
            if (ga || gl) begin
                m_last_alu = ga;
                if (real_reg(r)) begin
                    if (!m_owed[r]) m_err = 1'b1;
                    m_owed[r] = 1'b0;
                end
            end
            m_wen = (ga || gl) && real_reg(r);
            if (m_wen) begin
                m_waddr = r;
                m_wdata = d;
            end
            if (iss) begin
                m_pending[issue_rd] = 1'b1;
                m_owed[issue_rd]    = 1'b1;
            end
        end
    end

    always @(negedge clock) begin
        if (checking) begin
            chk("issue_ready", 32'(issue_ready), 32'(!m_busy(issue_rd)));
            chk("alu_ready",   32'(alu_ready),   32'(m_grant_alu()));
            chk("lsu_ready",   32'(lsu_ready),   32'(m_grant_lsu()));
            chk("rs1_busy",    32'(rs1_busy),    32'(m_busy(chk_rs1)));
            chk("rs2_busy",    32'(rs2_busy),    32'(m_busy(chk_rs2)));
            chk("gpr_wen",     32'(gpr_wen),     32'(m_wen));
            chk("wb_err",      32'(wb_err),      32'(m_err));
            if (m_wen) begin
                chk("gpr_waddr", 32'(gpr_waddr), 32'(m_waddr));
                chk("gpr_wdata", gpr_wdata,      m_wdata);
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        issue_valid = 0; issue_rd = 0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    endtask

    task automatic do_reset();
        reset = 0;
        idle();
        cyc();
        cyc();
        reset = 1;
    endtask

    task automatic issue(input logic [4:0] r);
        idle();
        issue_valid = 1; issue_rd = r;
        cyc();
        idle();
    endtask

    initial begin
        chk_rs1 = 0; chk_rs2 = 0;
        do_reset();
        checking = 1'b1;
        chk("rst_waddr", 32'(gpr_waddr), 32'd0);
        chk("rst_wdata", gpr_wdata, 32'd0);
        chk("rst_wen", 32'(gpr_wen), 32'd0);

        // Issue then ALU writeback with one-cycle latency
        chk_rs1 = 5;
        issue(5);
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        #1 chk("t28_alu_ready", 32'(alu_ready), 32'd1);
        chk("t28_rs1_pre", 32'(rs1_busy), 32'd1);
        cyc(); idle();
        chk("t28_wen", 32'(gpr_wen), 32'd1);
        chk("t28_waddr", 32'(gpr_waddr), 32'd5);
        chk("t28_wdata", gpr_wdata, 32'hDEADBEEF);
        chk("t28_rs1_commit", 32'(rs1_busy), 32'd1);
        cyc();
        chk("t28_rs1_after", 32'(rs1_busy), 32'd0);

        // Round-robin: ALU first, LSU second
        do_reset();
        issue(3); issue(4);
        alu_valid = 1; alu_rd = 3; alu_data = 32'h0A;
        lsu_valid = 1; lsu_rd = 4; lsu_data = 32'h0B;
        #1 chk("t29_alu_first", 32'(alu_ready), 32'd1);
        chk("t29_lsu_wait", 32'(lsu_ready), 32'd0);
        cyc();
        chk("t29_lsu_second", 32'(lsu_ready), 32'd1);
        chk("t29_wb_alu", 32'(gpr_waddr), 32'd3);
        cyc(); idle();
        chk("t29_wb_lsu", gpr_wdata, 32'h0B);
        alu_valid = 1; lsu_valid = 1;       // rd=0 on both: pref must be back at ALU
        #1 chk("t29_pref0", 32'(alu_ready), 32'd1);
        cyc(); idle();

        // WAW stall until commit of rd 7
        chk_rs2 = 7;
        issue(7);
        issue_valid = 1; issue_rd = 7;
        #1 chk("t30_stall", 32'(issue_ready), 32'd0);
        alu_valid = 1; alu_rd = 7; alu_data = 32'h77;
        cyc();
        alu_valid = 0;
        chk("t30_commit_wen", 32'(gpr_wen), 32'd1);
        chk("t30_still_stall", 32'(issue_ready), 32'd0);
        cyc();
        chk("t30_released", 32'(issue_ready), 32'd1);
        cyc(); idle();
        alu_valid = 1; alu_rd = 7; alu_data = 32'h78;
        cyc(); idle();

        // Writeback to x0 is dropped
        lsu_valid = 1; lsu_rd = 0; lsu_data = 32'h1234;
        #1 chk("t31_lsu_ready", 32'(lsu_ready), 32'd1);
        cyc(); idle();
        chk("t31_wen", 32'(gpr_wen), 32'd0);
        chk("t31_err", 32'(wb_err), 32'd0);
        cyc();

        // Reset in the same cycle as a handshake discards it
        issue(2);
        chk_rs1 = 2;
        alu_valid = 1; alu_rd = 2; alu_data = 32'h22;
        reset = 0;
        cyc(); reset = 1; idle();
        chk("t33_wen", 32'(gpr_wen), 32'd0);
        chk("t33_busy2", 32'(rs1_busy), 32'd0);
        alu_valid = 1; lsu_valid = 1;
        #1 chk("t33_pref0", 32'(alu_ready), 32'd1);
        cyc(); idle();

        // ALU then LSU to the same rd in successive cycles
        issue(11);
        alu_valid = 1; alu_rd = 11; alu_data = 32'h1;
        cyc(); idle();
        lsu_valid = 1; lsu_rd = 11; lsu_data = 32'h2;
        cyc(); idle();
        chk("t22_err", 32'(wb_err), 32'd1);
        do_reset();
        chk("t22_err_clr", 32'(wb_err), 32'd0);

        // Writeback to an idle register raises sticky error
        alu_valid = 1; alu_rd = 9; alu_data = 32'h99;
        cyc(); idle();
        chk("t32_wen", 32'(gpr_wen), 32'd1);
        chk("t32_waddr", 32'(gpr_waddr), 32'd9);
        chk("t32_err", 32'(wb_err), 32'd1);
        repeat (3) cyc();
        chk("t32_err_held", 32'(wb_err), 32'd1);

        // Random traffic against the model
        do_reset();
        for (int n = 0; n < 400; n++) begin
            reset       = ($urandom_range(0, 40) != 0);
            issue_valid = $urandom_range(0, 1) == 1;
            issue_rd    = 5'($urandom_range(0, 17));
            alu_valid   = $urandom_range(0, 2) == 0;
            alu_rd      = 5'($urandom_range(0, 17));
            alu_data    = $urandom;
            lsu_valid   = $urandom_range(0, 2) == 0;
            lsu_rd      = 5'($urandom_range(0, 17));
            lsu_data    = $urandom;
            chk_rs1     = 5'($urandom_range(0, 17));
            chk_rs2     = 5'($urandom_range(0, 31));
            cyc();
        end
        idle();
        reset = 1;
        cyc();
        checking = 1'b0;
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
